// File: rtl/branch_predict_btb.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_btb
// Purpose  : Direct-mapped branch target buffer with per-entry 2-bit
//            saturating counters. Supplies a zero-latency fetch prediction,
//            resolves branches in EX (flush + redirect on mispredict) and
//            trains the table on the following clock edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   if_valid, if_pc            fetch lookup request and PC
//   pred_taken, pred_target    predicted direction and next fetch PC
//   ex_valid, ex_is_branch     EX stage holds a valid (branch) instruction
//   ex_pc, ex_taken, ex_target resolved PC, outcome and target
//   ex_pred_taken/_target      prediction carried down with the instruction
//   flush, redirect_pc         squash younger instructions, PC to restart at
//   branch_count               resolved branches (saturating)
//   mispredict_count           mispredicts (saturating)
// ============================================================================
module branch_predict_btb #(
  parameter int         ADDR_W   = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Table storage. Tag and target need no reset: valid gates their use.
  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];

  logic [CNT_W-1:0]  r_branch_count;
  logic [CNT_W-1:0]  r_mispredict_count;

  // Fetch-side lookup
  logic [IDX_W-1:0]  w_if_idx;
  logic [TAG_W-1:0]  w_if_tag;
  logic              w_if_hit;
  logic [ADDR_W-1:0] w_if_seq;

  // EX-side resolve
  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_ex_hit;
  logic              w_res;
  logic              w_br_mispredict;
  logic              w_alias_mispredict;
  logic              w_flush;

  // Word-offset bits never take part in indexing or tagging.
  logic              w_unused_bits;
  assign w_unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_if_seq = if_pc + ADDR_W'(4);

  // The table reads pre-update contents: a same-cycle update to this index
  // only becomes visible on the next cycle.
  always_comb begin
    pred_taken  = if_valid && !reset && w_if_hit && r_ctr[w_if_idx][1];
    pred_target = pred_taken ? r_target[w_if_idx] : w_if_seq;
  end

  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_res    = ex_valid && !reset;

  // A target mismatch only matters when the branch was actually taken.
  assign w_br_mispredict = w_res && ex_is_branch &&
                           ((ex_pred_taken != ex_taken) ||
                            (ex_taken && (ex_pred_target != ex_target)));
  // A non-branch predicted taken means an aliased table entry redirected it.
  assign w_alias_mispredict = w_res && !ex_is_branch && ex_pred_taken;
  assign w_flush            = w_br_mispredict || w_alias_mispredict;

  assign flush       = w_flush;
  assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + ADDR_W'(4));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_INIT;
      end
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_res && ex_is_branch) begin
        if (w_ex_hit) begin
          if (ex_taken) begin
            if (r_ctr[w_ex_idx] != 2'b11) begin
              r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
            end
            r_target[w_ex_idx] <= ex_target;
          end else if (r_ctr[w_ex_idx] != 2'b00) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          // Allocation overwrites whatever occupies the slot (eviction).
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= ex_target;
          r_ctr[w_ex_idx]    <= 2'b10;
        end
      end else if (w_res && !ex_is_branch && w_ex_hit) begin
        r_valid[w_ex_idx] <= 1'b0;
      end

      if (w_res && ex_is_branch && (r_branch_count != {CNT_W{1'b1}})) begin
        r_branch_count <= r_branch_count + CNT_W'(1);
      end
      if (w_flush && (r_mispredict_count != {CNT_W{1'b1}})) begin
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_btb
// Purpose  : Directed scoreboard bench for branch_predict_btb. The driver
//            pushes a hand-computed expectation for each driven cycle; a
//            negedge monitor pops and compares against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_btb;

  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          ex_valid;
  logic          ex_is_branch;
  logic [AW-1:0] ex_pc;
  logic          ex_taken;
  logic [AW-1:0] ex_target;
  logic          ex_pred_taken;
  logic [AW-1:0] ex_pred_target;
  logic          flush;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  branch_predict_btb #(
    .ADDR_W(AW), .ENTRIES(16), .CTR_INIT(2'b01), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    bit            cp;   // check prediction
    bit            pt;
    logic [AW-1:0] ptg;
    bit            cr;   // check resolve
    bit            fl;
    logic [AW-1:0] rd;
    bit            cc;   // check statistics
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t q[$];
  bit   obs = 1'b0;
  bit   done = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input int id, input string nm, input logic [AW-1:0] act, input logic [AW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, nm, act, expv);
    end
  endtask

  // Monitor: one expectation per observed cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (obs) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard: empty queue at observed cycle");
        end else begin
          e = q.pop_front();
          if (e.cp) begin
            chk(e.id, "pred_taken", AW'(pred_taken), AW'(e.pt));
            chk(e.id, "pred_target", pred_target, e.ptg);
          end
          if (e.cr) begin
            chk(e.id, "flush", AW'(flush), AW'(e.fl));
            chk(e.id, "redirect_pc", redirect_pc, e.rd);
          end
          if (e.cc) begin
            chk(e.id, "branch_count", AW'(branch_count), AW'(e.bc));
            chk(e.id, "mispredict_count", AW'(mispredict_count), AW'(e.mc));
          end
        end
      end
    end
  end

  task automatic idle();
    if_valid = 0; if_pc = '0;
    ex_valid = 0; ex_is_branch = 0; ex_pc = '0; ex_taken = 0;
    ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic look(input logic [AW-1:0] pc);
    if_valid = 1; if_pc = pc;
  endtask

  task automatic resolve(input bit br, input logic [AW-1:0] pc, input bit tk,
                         input logic [AW-1:0] tg, input bit ppt, input logic [AW-1:0] ptg);
    ex_valid = 1; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
    ex_target = tg; ex_pred_taken = ppt; ex_pred_target = ptg;
  endtask

  // Queue the expectation, let the monitor see this cycle, then advance.
  task automatic step(input int id,
                      input bit cp, input bit pt, input logic [AW-1:0] ptg,
                      input bit cr, input bit fl, input logic [AW-1:0] rd,
                      input bit cc, input logic [CW-1:0] bc, input logic [CW-1:0] mc);
    exp_t e;
    e.id = id; e.cp = cp; e.pt = pt; e.ptg = ptg;
    e.cr = cr; e.fl = fl; e.rd = rd; e.cc = cc; e.bc = bc; e.mc = mc;
    q.push_back(e);
    obs = 1'b1;
    @(posedge clk); #1;
    obs = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // 1: first lookup after reset misses; stats cleared
    look(32'h40);
    step(1, 1, 0, 32'h44, 0, 0, 0, 1, 0, 0);
    // 2: taken, predicted not-taken -> allocate; same-cycle lookup still misses
    look(32'h40); resolve(1, 32'h40, 1, 32'h100, 0, 32'h44);
    step(2, 1, 0, 32'h44, 1, 1, 32'h100, 1, 0, 0);
    // 3: newly allocated entry (ctr=10) predicts taken
    look(32'h40);
    step(3, 1, 1, 32'h100, 0, 0, 0, 1, 1, 1);
    // 4: not taken while predicted taken -> flush to fall-through, ctr 10->01
    resolve(1, 32'h40, 0, 32'h0, 1, 32'h100);
    step(4, 0, 0, 0, 1, 1, 32'h44, 1, 1, 1);
    // 5: not taken, predicted not-taken -> no flush, ctr 01->00; lookup sees 01
    look(32'h40); resolve(1, 32'h40, 0, 32'h0, 0, 32'h44);
    step(5, 1, 0, 32'h44, 1, 0, 32'h44, 1, 2, 2);
    // 6-7: further not-taken resolves keep ctr at 00
    look(32'h40); resolve(1, 32'h40, 0, 32'h0, 0, 32'h44);
    step(6, 1, 0, 32'h44, 1, 0, 32'h44, 1, 3, 2);
    resolve(1, 32'h40, 0, 32'h0, 0, 32'h44);
    step(7, 0, 0, 0, 1, 0, 32'h44, 1, 4, 2);
    // 8: taken from 00 -> 01 (a wrapped counter would end up predicting taken)
    look(32'h40); resolve(1, 32'h40, 1, 32'h100, 0, 32'h44);
    step(8, 1, 0, 32'h44, 1, 1, 32'h100, 1, 5, 2);
    look(32'h40);
    step(9, 1, 0, 32'h44, 0, 0, 0, 1, 6, 3);
    // 10-11: taken again -> ctr 10 -> predicts taken
    resolve(1, 32'h40, 1, 32'h100, 0, 32'h44);
    step(10, 0, 0, 0, 1, 1, 32'h100, 1, 6, 3);
    look(32'h40);
    step(11, 1, 1, 32'h100, 0, 0, 0, 1, 7, 4);
    // 12-14: 0x80 shares index 0 with a different tag and evicts 0x40
    resolve(1, 32'h80, 1, 32'h300, 0, 32'h84);
    step(12, 0, 0, 0, 1, 1, 32'h300, 1, 7, 4);
    look(32'h40);
    step(13, 1, 0, 32'h44, 0, 0, 0, 1, 8, 5);
    look(32'h80);
    step(14, 1, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    // 15-16: non-branch at 0x80 predicted taken -> alias flush, entry invalidated
    resolve(0, 32'h80, 0, 32'h0, 1, 32'h300);
    step(15, 0, 0, 0, 1, 1, 32'h84, 1, 8, 5);
    look(32'h80);
    step(16, 1, 0, 32'h84, 0, 0, 0, 1, 8, 6);
    // 17-19: right direction, wrong target -> flush to real target, retrain
    resolve(1, 32'h40, 1, 32'h100, 0, 32'h44);
    step(17, 0, 0, 0, 1, 1, 32'h100, 1, 8, 6);
    resolve(1, 32'h40, 1, 32'h200, 1, 32'h100);
    step(18, 0, 0, 0, 1, 1, 32'h200, 1, 9, 7);
    look(32'h40);
    step(19, 1, 1, 32'h200, 0, 0, 0, 1, 10, 8);
    // 20: correct taken prediction -> no flush
    resolve(1, 32'h40, 1, 32'h200, 1, 32'h200);
    step(20, 0, 0, 0, 1, 0, 32'h200, 1, 10, 8);
    // 21: non-branch without prediction -> no flush, redirect is pc+4
    resolve(0, 32'h14, 0, 32'h0, 0, 32'h18);
    step(21, 0, 0, 0, 1, 0, 32'h18, 1, 11, 8);
    // 22-25: index 5 read-during-write returns pre-update contents
    look(32'h14); resolve(1, 32'h14, 1, 32'h500, 0, 32'h18);
    step(22, 1, 0, 32'h18, 1, 1, 32'h500, 1, 11, 8);
    look(32'h14);
    step(23, 1, 1, 32'h500, 0, 0, 0, 1, 12, 9);
    look(32'h14); resolve(1, 32'h14, 1, 32'h600, 1, 32'h500);
    step(24, 1, 1, 32'h500, 1, 1, 32'h600, 1, 12, 9);
    look(32'h14);
    step(25, 1, 1, 32'h600, 0, 0, 0, 1, 13, 10);
    // 26: fall-through wraps modulo 2^32
    look(32'hFFFF_FFFC);
    step(26, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    // 27: reset concurrent with a mispredicting resolve -> no flush, no update
    reset = 1;
    look(32'h40); resolve(1, 32'h54, 1, 32'h700, 0, 32'h58);
    step(27, 1, 0, 32'h44, 1, 0, 32'h700, 1, 13, 10);
    reset = 0;
    // 28-29: dropped update never allocated; old entries gone; stats cleared
    look(32'h54);
    step(28, 1, 0, 32'h58, 0, 0, 0, 1, 0, 0);
    look(32'h40);
    step(29, 1, 0, 32'h44, 0, 0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard drain: %0d expectations left, required 0", q.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predict_btb.md
Name: branch_predict_btb

Overview:
- Parametrised successor to the combinational branch-condition/target-select path.
- Predicts fetch-stage redirects with a direct-mapped branch target buffer (BTB) and per-entry 2-bit saturating counters.
- Resolves each branch in EX: compares the actual outcome with the carried prediction, raises flush plus redirect PC on mispredict, and trains the table.
- Sits between the IF PC mux (prediction outputs) and the EX branch-condition logic (resolution inputs).

Parameters:
- ADDR_W, 32, PC/target width in bits.
- ENTRIES, 16, BTB depth; power of two, at least 2. IDX_W = log2(ENTRIES).
- CTR_INIT, 2'b01, counter value loaded on reset (weakly not-taken).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_valid  in  1  fetch lookup request
- if_pc  in  ADDR_W  fetch PC
- pred_taken  out  1  predict taken this fetch
- pred_target  out  ADDR_W  predicted next PC
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_branch  in  1  EX instruction is a branch or jump
- ex_pc  in  ADDR_W  EX instruction PC
- ex_taken  in  1  resolved outcome (from the condition handler)
- ex_target  in  ADDR_W  resolved target
- ex_pred_taken  in  1  prediction carried down the pipeline with this instruction
- ex_pred_target  in  ADDR_W  predicted target carried with this instruction
- flush  out  1  squash younger IF/ID instructions
- redirect_pc  out  ADDR_W  PC to load when flush=1
- branch_count  out  CNT_W  resolved branches
- mispredict_count  out  CNT_W  mispredicts

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2].
- Entry contents: valid, tag, target, ctr[1:0].
- Lookup (combinational):
  - hit = valid & tag match.
  - pred_taken = if_valid & hit & ctr[1].
  - pred_target = pred_taken ? entry.target : if_pc+4, with +4 wrapping modulo 2^ADDR_W.
- Resolve (combinational), with res = ex_valid & ~reset:
  - Branch mispredict: res & ex_is_branch & (ex_pred_taken != ex_taken | (ex_taken & ex_pred_target != ex_target)).
  - Alias mispredict: res & ~ex_is_branch & ex_pred_taken.
  - flush = branch mispredict | alias mispredict.
  - redirect_pc = (ex_is_branch & ex_taken) ? ex_target : ex_pc+4.
  - When flush=0, redirect_pc is don't-care but must be driven, not X.
- Update (registered, next clk edge, when res & ex_is_branch), on the ex_pc entry:
  - Miss and taken: allocate; valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss and not taken: no allocation.
  - Hit and taken: ctr=min(ctr+1,3); target=ex_target.
  - Hit and not taken: ctr=max(ctr-1,0); target unchanged.
  - Counters saturate at 2'b11 and 2'b00 with no wrap.
- Alias clean-up: res & ~ex_is_branch & tag hit clears that entry's valid bit.
- Statistics:
  - branch_count increments on res & ex_is_branch.
  - mispredict_count increments on flush.
  - Both saturate at all-ones.
- Read-during-write: a lookup and an update to the same index in one cycle return the pre-update contents. No bypass.
- Reset (synchronous):
  - All valid=0, ctr=CTR_INIT, both statistics counters=0.
  - While reset=1, pred_taken=0, pred_target=if_pc+4, flush=0.
  - Reset asserted mid-stream drops the pending update.
  - First lookup after reset deassertion misses.
- Latency: prediction 0 cycles; flush 0 cycles from EX inputs; table update visible to a lookup in the next cycle.

Test Plan:
- After reset, lookup if_pc=0x40 -> pred_taken=0, pred_target=0x44; both statistics counters=0.
- Resolve ex_pc=0x40, taken, ex_target=0x100, ex_pred_taken=0 -> flush=1, redirect_pc=0x100, mispredict_count=1. Next cycle lookup 0x40 -> pred_taken=1, pred_target=0x100.
- Train 0x40 not-taken twice from ctr=2'b10 -> ctr goes 01 then 00. Then lookup -> pred_taken=0. Two further not-taken resolves leave ctr=00 (saturation). A resolve with ex_pred_taken=0 gives flush=0.
- ENTRIES=16: ex_pc=0x40 and 0x80 share index 0 with different tags. 0x80 taken evicts 0x40. Lookup 0x40 misses. Non-branch at 0x80 with ex_pred_taken=1 -> flush=1, redirect_pc=0x84, entry invalidated.
- Correct direction, wrong target: ex_pred_target=0x100, ex_target=0x200 -> flush=1, redirect_pc=0x200, entry target updated to 0x200.
- Same-cycle lookup/update on index 5 -> lookup returns old entry. Reset asserted in the same cycle as a resolve -> no update, flush=0, counters=0.
